// File: rtl/lifo_pkg.sv
// Shared definitions for the multi-channel LIFO: width helpers and error codes.
package lifo_pkg;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel index width; at least one bit so a single-channel build still has a port.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? clog2(channels) : 1;
  endfunction

  // Pointer width for a stack of the given depth.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  // Occupancy width: must be able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2
  } err_e;

endpackage

// File: rtl/lifo_ctx_ctrl.sv
// Per-channel stack bookkeeping: write pointer, occupancy, wrap handling and
// the write request / error classification for one already-qualified operation.
module lifo_ctx_ctrl
  import lifo_pkg::*;
#(
  parameter int  DEPTH        = 32,
  parameter int  WRAP_ON_FULL = 0,
  localparam int PTR_W        = ptr_width(DEPTH),
  localparam int CNT_W        = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W-1:0] top_ptr,
  output logic [PTR_W-1:0] wr_idx,
  output logic             wr_en,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty_n,
  output err_e             err
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty_n = (count != '0);

  // DEPTH need not be a power of two, so both directions wrap explicitly.
  assign ptr_inc = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
  assign top_ptr = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - PTR_W'(1);

  // Decode the operation in priority order: flush, replace, push, pop.
  always_comb begin
    ptr_nxt = wr_ptr;
    cnt_nxt = count;
    wr_en   = 1'b0;
    wr_idx  = wr_ptr;
    err     = ERR_NONE;
    if (flush) begin
      ptr_nxt = '0;
      cnt_nxt = '0;
    end else if (push && pop && empty_n) begin
      // Replace top in place; push+pop on an empty stack falls through to a plain push.
      wr_en  = 1'b1;
      wr_idx = top_ptr;
    end else if (push) begin
      if (!full) begin
        wr_en   = 1'b1;
        ptr_nxt = ptr_inc;
        cnt_nxt = count + CNT_W'(1);
      end else begin
        err = ERR_OVERFLOW;
        if (WRAP_ON_FULL != 0) begin
          // Circular mode: the slot at wr_ptr holds the oldest entry, overwrite it.
          wr_en   = 1'b1;
          ptr_nxt = ptr_inc;
        end
      end
    end else if (pop) begin
      if (empty_n) begin
        ptr_nxt = top_ptr;
        cnt_nxt = count - CNT_W'(1);
      end else begin
        err = ERR_UNDERFLOW;
      end
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= ptr_nxt;
      count  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/lifo_stack_mc.sv
// Multi-channel LIFO stack: CHANNELS independent stacks in one shared
// register array, with per-channel full/empty flags and error reporting.
module lifo_stack_mc
  import lifo_pkg::*;
#(
  parameter int  WIDTH        = 32,
  parameter int  DEPTH        = 32,
  parameter int  CHANNELS     = 2,
  parameter int  WRAP_ON_FULL = 0,
  localparam int CH_W         = ch_width(CHANNELS),
  localparam int PTR_W        = ptr_width(DEPTH),
  localparam int CNT_W        = cnt_width(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CH_W-1:0]     ch_sel,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  input  logic                flush,
  output logic [WIDTH-1:0]    tos,
  output logic [CNT_W-1:0]    count,
  output logic [CHANNELS-1:0] empty_n,
  output logic [CHANNELS-1:0] full,
  output logic                overflow,
  output logic                underflow,
  output logic [CH_W-1:0]     err_ch
);

  localparam int ENTRIES = CHANNELS * DEPTH;
  localparam int ADDR_W  = ptr_width(ENTRIES);

  // Flat address of slot idx in channel ch's region.
  function automatic logic [ADDR_W-1:0] mem_addr(input logic [CH_W-1:0] ch,
                                                 input logic [PTR_W-1:0] idx);
    return ADDR_W'(int'(ch) * DEPTH + int'(idx));
  endfunction

  logic [WIDTH-1:0] mem [ENTRIES];

  logic [PTR_W-1:0] top_ptr_a [CHANNELS];
  logic [PTR_W-1:0] wr_idx_a  [CHANNELS];
  logic             wr_en_a   [CHANNELS];
  logic [CNT_W-1:0] count_a   [CHANNELS];
  err_e             err_a     [CHANNELS];

  logic             sel_wr_en;
  logic [PTR_W-1:0] sel_wr_idx;
  logic [PTR_W-1:0] sel_top;
  logic [CNT_W-1:0] sel_cnt;
  err_e             sel_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Only the addressed channel sees the strobes, so the others hold state.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic sel;
    assign sel = (ch_sel == CH_W'(c));

    lifo_ctx_ctrl #(
      .DEPTH        (DEPTH),
      .WRAP_ON_FULL (WRAP_ON_FULL)
    ) u_ctrl (
      .clk     (clk),
      .reset   (reset),
      .push    (push & sel),
      .pop     (pop & sel),
      .flush   (flush & sel),
      .top_ptr (top_ptr_a[c]),
      .wr_idx  (wr_idx_a[c]),
      .wr_en   (wr_en_a[c]),
      .count   (count_a[c]),
      .full    (full[c]),
      .empty_n (empty_n[c]),
      .err     (err_a[c])
    );
  end

  // Pick the addressed channel's controls; an out-of-range ch_sel selects nothing.
  always_comb begin
    sel_wr_en  = 1'b0;
    sel_wr_idx = '0;
    sel_top    = '0;
    sel_cnt    = '0;
    sel_err    = ERR_NONE;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel == CH_W'(c)) begin
        sel_wr_en  = wr_en_a[c];
        sel_wr_idx = wr_idx_a[c];
        sel_top    = top_ptr_a[c];
        sel_cnt    = count_a[c];
        sel_err    = err_a[c];
      end
    end
  end

  assign wr_addr = mem_addr(ch_sel, sel_wr_idx);
  assign rd_addr = mem_addr(ch_sel, sel_top);

  // Shared storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (sel_wr_en) mem[wr_addr] <= push_data;
  end

  // Read is combinational from registered state so a write is visible right after its edge.
  assign tos   = (sel_cnt != '0) ? mem[rd_addr] : '0;
  assign count = sel_cnt;

  // Error pulses last one cycle; err_ch remembers the channel of the latest error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      err_ch    <= '0;
    end else begin
      overflow  <= (sel_err == ERR_OVERFLOW);
      underflow <= (sel_err == ERR_UNDERFLOW);
      if (sel_err != ERR_NONE) err_ch <= ch_sel;
    end
  end

endmodule

// File: tb/tb_lifo_stack_mc.sv
// Bench for lifo_stack_mc: a drop-on-full and a wrap-on-full instance share
// the same stimulus and are compared against a list-based stack model.
module tb_lifo_stack_mc;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CH = 2;

  typedef logic [W+3+2+2+3-1:0] vec_t;

  typedef struct {
    int         ch;
    bit         ps;
    bit         pp;
    bit         fl;
    bit         tick;
    logic [W-1:0] d;
  } op_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:0]   ch_sel;
  logic         push, pop, flush;
  logic [W-1:0] push_data;

  logic [W-1:0] tos0, tos1;
  logic [2:0]   count0, count1;
  logic [1:0]   empty_n0, empty_n1, full0, full1;
  logic         overflow0, overflow1, underflow0, underflow1;
  logic [0:0]   err_ch0, err_ch1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: st[v][ch][0] is the oldest entry, st[v][ch][n-1] the top.
  logic [W-1:0] st [2][CH][D];
  int           n  [2][CH];
  logic         exp_ovf [2];
  logic         exp_udf [2];
  logic [0:0]   exp_err [2];

  always #5 clk = ~clk;

  lifo_stack_mc #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH), .WRAP_ON_FULL(0)) dut0 (
    .clk(clk), .reset(reset), .ch_sel(ch_sel), .push(push), .push_data(push_data),
    .pop(pop), .flush(flush), .tos(tos0), .count(count0), .empty_n(empty_n0),
    .full(full0), .overflow(overflow0), .underflow(underflow0), .err_ch(err_ch0));

  lifo_stack_mc #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH), .WRAP_ON_FULL(1)) dut1 (
    .clk(clk), .reset(reset), .ch_sel(ch_sel), .push(push), .push_data(push_data),
    .pop(pop), .flush(flush), .tos(tos1), .count(count1), .empty_n(empty_n1),
    .full(full1), .overflow(overflow1), .underflow(underflow1), .err_ch(err_ch1));

  function automatic op_t mk(int ch, bit ps, bit pp, bit fl, bit tick, logic [W-1:0] d);
    op_t o;
    o.ch = ch; o.ps = ps; o.pp = pp; o.fl = fl; o.tick = tick; o.d = d;
    return o;
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < 2; v++) begin
      for (int c = 0; c < CH; c++) n[v][c] = 0;
      exp_ovf[v] = 1'b0;
      exp_udf[v] = 1'b0;
      exp_err[v] = 1'b0;
    end
  endfunction

  // One clock edge of behaviour for both variants (v=1 is the circular one).
  function automatic void model_step(int ch, bit ps, bit pp, bit fl, logic [W-1:0] d);
    for (int v = 0; v < 2; v++) begin
      exp_ovf[v] = 1'b0;
      exp_udf[v] = 1'b0;
      if (fl) begin
        n[v][ch] = 0;
      end else if (ps && pp && n[v][ch] > 0) begin
        st[v][ch][n[v][ch]-1] = d;
      end else if (ps) begin
        if (n[v][ch] < D) begin
          st[v][ch][n[v][ch]] = d;
          n[v][ch]++;
        end else begin
          exp_ovf[v] = 1'b1;
          exp_err[v] = 1'(ch);
          if (v == 1) begin
            for (int i = 0; i < D - 1; i++) st[v][ch][i] = st[v][ch][i+1];
            st[v][ch][D-1] = d;
          end
        end
      end else if (pp) begin
        if (n[v][ch] > 0) n[v][ch]--;
        else begin
          exp_udf[v] = 1'b1;
          exp_err[v] = 1'(ch);
        end
      end
    end
  endfunction

  function automatic vec_t exp_vec(int v);
    int c;
    logic [1:0] en, fu;
    logic [W-1:0] t;
    c = int'(ch_sel);
    for (int k = 0; k < CH; k++) begin
      en[k] = (n[v][k] != 0);
      fu[k] = (n[v][k] == D);
    end
    t = (n[v][c] > 0) ? st[v][c][n[v][c]-1] : '0;
    return {t, 3'(n[v][c]), en, fu, exp_ovf[v], exp_udf[v], exp_err[v]};
  endfunction

  function automatic vec_t obs_vec(int v);
    if (v == 0) return {tos0, count0, empty_n0, full0, overflow0, underflow0, err_ch0};
    return {tos1, count1, empty_n1, full1, overflow1, underflow1, err_ch1};
  endfunction

  // Apply one op: either a clocked operation or just a ch_sel change.
  task automatic run_op(op_t o);
    ch_sel = 1'(o.ch);
    if (o.tick) begin
      push = o.ps; pop = o.pp; flush = o.fl; push_data = o.d;
      @(posedge clk);
      model_step(o.ch, o.ps, o.pp, o.fl, o.d);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0;
    end else begin
      #1;
    end
  endtask

  task automatic test_reset();
    for (int v = 0; v < 2; v++) begin
      n_checks++;
      if (obs_vec(v) !== vec_t'(0)) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h expected %h", v, obs_vec(v), vec_t'(0));
      end
    end
  endtask

  task automatic test_push_pop();
    op_t ops[$];
    ops.push_back(mk(0, 1, 0, 0, 1, 16'h000A));
    ops.push_back(mk(0, 1, 0, 0, 1, 16'h000B));
    ops.push_back(mk(0, 1, 0, 0, 1, 16'h000C));
    ops.push_back(mk(1, 0, 0, 0, 0, 16'h0));
    ops.push_back(mk(0, 0, 0, 0, 0, 16'h0));
    for (int i = 0; i < 4; i++) ops.push_back(mk(0, 0, 1, 0, 1, 16'h0));
    ops.push_back(mk(0, 0, 0, 0, 1, 16'h0));
    foreach (ops[i]) begin
      run_op(ops[i]);
      for (int v = 0; v < 2; v++) begin
        n_checks++;
        if (obs_vec(v) !== exp_vec(v)) begin
          n_fail++;
          $display("FAIL push_pop dut%0d step%0d: got %h expected %h", v, i, obs_vec(v), exp_vec(v));
        end
      end
    end
  endtask

  task automatic test_replace();
    op_t ops[$];
    ops.push_back(mk(1, 1, 0, 0, 1, 16'h0005));
    ops.push_back(mk(1, 1, 1, 0, 1, 16'h0007));
    ops.push_back(mk(0, 1, 1, 0, 1, 16'h0033));
    ops.push_back(mk(0, 0, 0, 0, 1, 16'h0));
    ops.push_back(mk(1, 0, 0, 0, 0, 16'h0));
    foreach (ops[i]) begin
      run_op(ops[i]);
      for (int v = 0; v < 2; v++) begin
        n_checks++;
        if (obs_vec(v) !== exp_vec(v)) begin
          n_fail++;
          $display("FAIL replace dut%0d step%0d: got %h expected %h", v, i, obs_vec(v), exp_vec(v));
        end
      end
    end
  endtask

  task automatic test_full();
    op_t ops[$];
    ops.push_back(mk(1, 0, 0, 1, 1, 16'h0));
    for (int k = 1; k <= 6; k++) ops.push_back(mk(1, 1, 0, 0, 1, 16'(k)));
    for (int k = 0; k < 5; k++) ops.push_back(mk(1, 0, 1, 0, 1, 16'h0));
    ops.push_back(mk(1, 0, 0, 0, 1, 16'h0));
    foreach (ops[i]) begin
      run_op(ops[i]);
      for (int v = 0; v < 2; v++) begin
        n_checks++;
        if (obs_vec(v) !== exp_vec(v)) begin
          n_fail++;
          $display("FAIL full dut%0d step%0d: got %h expected %h", v, i, obs_vec(v), exp_vec(v));
        end
      end
    end
  endtask

  task automatic test_flush();
    op_t ops[$];
    ops.push_back(mk(0, 1, 0, 0, 1, 16'h0101));
    ops.push_back(mk(0, 1, 0, 0, 1, 16'h0202));
    ops.push_back(mk(1, 1, 0, 0, 1, 16'h1111));
    ops.push_back(mk(1, 1, 0, 0, 1, 16'h2222));
    ops.push_back(mk(0, 1, 1, 1, 1, 16'hDEAD));
    ops.push_back(mk(0, 0, 1, 1, 1, 16'h0));
    ops.push_back(mk(1, 0, 0, 0, 0, 16'h0));
    ops.push_back(mk(0, 0, 0, 0, 0, 16'h0));
    foreach (ops[i]) begin
      run_op(ops[i]);
      for (int v = 0; v < 2; v++) begin
        n_checks++;
        if (obs_vec(v) !== exp_vec(v)) begin
          n_fail++;
          $display("FAIL flush dut%0d step%0d: got %h expected %h", v, i, obs_vec(v), exp_vec(v));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) run_op(mk(1, 1, 0, 0, 1, 16'(16'h40 + k)));
    run_op(mk(0, 1, 0, 0, 1, 16'h0050));
    // Mid-burst: push held high while reset arrives between edges.
    ch_sel = 1'b0; push = 1'b1; push_data = 16'h0077;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int v = 0; v < 2; v++) begin
      n_checks++;
      if (obs_vec(v) !== exp_vec(v)) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: got %h expected %h", v, obs_vec(v), exp_vec(v));
      end
    end
    @(posedge clk);
    #1;
    ch_sel = 1'b1;
    #1;
    for (int v = 0; v < 2; v++) begin
      n_checks++;
      if (obs_vec(v) !== exp_vec(v)) begin
        n_fail++;
        $display("FAIL reset_hold dut%0d: got %h expected %h", v, obs_vec(v), exp_vec(v));
      end
    end
    push = 1'b0;
    #1;
    reset = 1'b0;
    run_op(mk(1, 1, 0, 0, 1, 16'h0009));
    for (int v = 0; v < 2; v++) begin
      n_checks++;
      if (obs_vec(v) !== exp_vec(v)) begin
        n_fail++;
        $display("FAIL post_reset dut%0d: got %h expected %h", v, obs_vec(v), exp_vec(v));
      end
    end
  endtask

  task automatic test_random();
    op_t o;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 31);
      o = mk($urandom_range(0, 1), 0, 0, 0, 1, 16'($urandom));
      if (r == 0)       o.fl = 1'b1;
      else if (r == 1)  o.tick = 1'b0;
      else if (r < 4)   begin o.ps = 1'b1; o.pp = 1'b1; end
      else if (r < 19)  o.ps = 1'b1;
      else if (r < 30)  o.pp = 1'b1;
      run_op(o);
      for (int v = 0; v < 2; v++) begin
        n_checks++;
        if (obs_vec(v) !== exp_vec(v)) begin
          n_fail++;
          $display("FAIL random dut%0d op%0d: got %h expected %h", v, i, obs_vec(v), exp_vec(v));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ch_sel = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
    model_reset();
    #3;
    test_reset();
    #4;
    reset = 1'b0;
    #1;
    test_push_pop();
    test_replace();
    test_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
